// File: rtl/div3_sweep_pkg.sv
// Shared definitions for the divisible-by-3 sweep controller and its golden model.
package div3_sweep_pkg;

    localparam int OPERAND_W      = 4;
    localparam int VECTORS        = 16;
    localparam int SETTLE_DEFAULT = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

endpackage

// File: rtl/div3_sweep_ctrl_ref.sv
// Golden model: high when the 4-bit operand is an exact multiple of three.
module div3_ref
    import div3_sweep_pkg::*;
(
    input  logic [OPERAND_W-1:0] operand,
    output logic                 div3
);

    assign div3 = ((operand % 4'd3) == 4'd0);

endmodule

// File: rtl/div3_sweep_ctrl.sv
// Sweeps all 4-bit operands into an external divisible-by-3 circuit and
// compares its y output against the golden model after a settle delay.
//
// state     | meaning
// ST_IDLE   | waiting for start; results of last sweep held
// ST_DRIVE  | operand presented on abcd for one cycle
// ST_WAIT   | settle countdown, SETTLE cycles
// ST_CHECK  | compare y against golden model, advance operand
// ST_FINISH | one-cycle done pulse, pass valid
module div3_sweep_ctrl
    import div3_sweep_pkg::*;
#(
    parameter int SETTLE = SETTLE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       y,
    output logic [3:0] abcd,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic       fail_valid,
    output logic [3:0] first_fail
);

    localparam logic [3:0]           SETTLE_LOAD  = 4'(SETTLE - 1);
    localparam logic [OPERAND_W-1:0] LAST_OPERAND = OPERAND_W'(VECTORS - 1);

    state_t     state;
    logic [3:0] wait_cnt;
    logic       y_exp;
    logic       mismatch;
    logic [4:0] err_next;

    div3_ref u_ref (
        .operand (abcd),
        .div3    (y_exp)
    );

    assign mismatch = (y != y_exp);
    assign err_next = err_count + 5'(mismatch);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            abcd       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
            wait_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_DRIVE;
                        busy       <= 1'b1;
                        abcd       <= '0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        first_fail <= '0;
                        pass       <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    if (abort) begin
                        state <= ST_FINISH;
                        done  <= 1'b1;
                        pass  <= 1'b0;
                    end else begin
                        state    <= ST_WAIT;
                        wait_cnt <= SETTLE_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (abort) begin
                        state <= ST_FINISH;
                        done  <= 1'b1;
                        pass  <= 1'b0;
                    end else if (wait_cnt == 4'd0) begin
                        state <= ST_CHECK;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (abort) begin
                        // comparison for the current operand is dropped
                        state <= ST_FINISH;
                        done  <= 1'b1;
                        pass  <= 1'b0;
                    end else begin
                        err_count <= err_next;
                        if (mismatch && !fail_valid) begin
                            fail_valid <= 1'b1;
                            first_fail <= abcd;
                        end
                        if (abcd == LAST_OPERAND) begin
                            state <= ST_FINISH;
                            done  <= 1'b1;
                            pass  <= (err_next == 5'd0);
                        end else begin
                            abcd  <= abcd + 4'd1;
                            state <= ST_DRIVE;
                        end
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/div3_sweep_ctrl.md
DIV3_SWEEP_CTRL -- requirements
Module: div3_sweep_ctrl

Interface
REQ-001: Parameter SETTLE, default 2, wait cycles between driving an operand and sampling y; legal range 1..15.
REQ-002: clk  input  1  single clock; all state updates on its rising edge.
REQ-003: rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004: start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
REQ-005: abort  input  1  terminates a running sweep; ignored in IDLE.
REQ-006: y  input  1  DUT divisible-by-3 output under test.
REQ-007: abcd  output  4  operand driven to DUT; abcd[3]=A (MSB) .. abcd[0]=D.
REQ-008: busy  output  1  high in every state except IDLE.
REQ-009: done  output  1  one-cycle pulse when a sweep completes or is aborted.
REQ-010: pass  output  1  high when the last completed sweep had zero mismatches; held until next accepted start.
REQ-011: err_count  output  5  mismatch count of current/last sweep, range 0..16.
REQ-012: fail_valid  output  1  high once any mismatch is recorded in current/last sweep.
REQ-013: first_fail  output  4  operand of first mismatch; valid only while fail_valid=1.

Function
REQ-014: FSM states IDLE, DRIVE, WAIT, CHECK, FINISH; all outputs registered.
REQ-015: IDLE + start=1 -> DRIVE; same edge clears abcd, err_count, fail_valid, first_fail, pass.
REQ-016: DRIVE: one cycle, abcd holds current operand -> WAIT with wait counter loaded to SETTLE-1.
REQ-017: WAIT: counter decrements each cycle; at 0 -> CHECK (WAIT lasts exactly SETTLE cycles).
REQ-018: CHECK: expected = (abcd mod 3 == 0); y != expected -> err_count+1; first mismatch also sets fail_valid=1, first_fail=abcd.
REQ-019: CHECK with abcd<15 -> abcd+1, DRIVE; abcd==15 -> FINISH; no wrap beyond 15.
REQ-020: Each operand takes SETTLE+2 cycles; full sweep 16*(SETTLE+2) cycles from start-accept edge to FINISH entry (64 for SETTLE=2).
REQ-021: FINISH: one cycle, done=1, pass=(err_count==0) including any mismatch from final CHECK -> IDLE.
REQ-022: abort=1 in DRIVE/WAIT/CHECK -> FINISH next edge; pending CHECK comparison discarded; pass forced 0.
REQ-023: abort and start together in IDLE: start wins, abort ignored.
REQ-024: start while busy ignored, no effect on sweep.
REQ-025: Operands 0,3,6,9,12,15 expect y=1; all others expect y=0.
REQ-026: err_count is 5 bits and never overflows (max 16); no saturation logic.
REQ-027: abcd holds its last value in IDLE after a sweep.

Reset
REQ-028: rst_n=0 at a rising edge forces IDLE, abcd=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail=0, wait counter=0.
REQ-029: Reset mid-sweep aborts with no done pulse; reset has priority over start and abort.

Structure
REQ-030: Shared package holds state encoding, VECTORS=16, default SETTLE, operand width 4.
REQ-031: Golden-model sub-module div3_ref (4-bit in, 1-bit out, combinational) produces expected; instantiated once.

Verification
REQ-032: Correct DUT, SETTLE=2, start pulse -> done at cycle 64 after accept, pass=1, err_count=0, fail_valid=0.
REQ-033: DUT stuck y=0 -> err_count=6, first_fail=0, pass=0.
REQ-034: DUT inverted output -> err_count=16, first_fail=0; DUT wrong only at 9 -> err_count=1, first_fail=9.
REQ-035: abort asserted during WAIT of operand 5 -> FINISH next edge, done pulse, pass=0, abcd=5, busy=0 one cycle later.
REQ-036: rst_n low mid-sweep (operand 7) -> all outputs reset values next edge, no done; new start sweeps from 0.
REQ-037: SETTLE=1 and SETTLE=15 -> sweep lengths 48 and 272 cycles; start held high during sweep causes no restart.
